// File: rtl/multicycle_controller.sv
// ---------------------------------------------------------------------------
// multicycle_controller
//
// Purpose:
//   Multi-cycle control FSM for a shared-datapath processor. Each instruction
//   is sequenced through FETCH, DECODE, EXEC and, where needed, MEM and WB.
//   One memory port serves both instruction fetch and data access through a
//   req/ready handshake. If memory stays silent too long, the FSM parks in
//   HALT with a sticky timeout flag.
//
// Ports:
//   clk         in   1      clock, rising edge
//   rst         in   1      asynchronous active-high reset
//   opcode      in   4      IR[15:12], sampled in DECODE
//   zero        in   1      ALU zero flag, used in EXEC for BEQ
//   mem_ready   in   1      memory completes the current access this cycle
//   mem_req     out  1      memory access request
//   mem_we      out  1      memory write (SW data phase)
//   iord        out  1      address mux: 0 = PC, 1 = ALU result
//   ir_we       out  1      load IR from memory read data
//   pc_we       out  1      load PC
//   pc_src      out  1      0 = PC+1, 1 = branch target
//   reg_we      out  1      register file write
//   mem_to_reg  out  1      writeback mux: 0 = ALU, 1 = memory data
//   state       out  3      current state (debug)
//   illegal     out  1      one-cycle pulse after an illegal opcode
//   timeout     out  1      sticky memory-timeout flag
//   retired     out  CNT_W  completed-instruction count (wraps)
// ---------------------------------------------------------------------------
module multicycle_controller #(
  parameter int MAX_WAIT = 15,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_we,
  output logic             pc_we,
  output logic             pc_src,
  output logic             reg_we,
  output logic             mem_to_reg,
  output logic [2:0]       state,
  output logic             illegal,
  output logic             timeout,
  output logic [CNT_W-1:0] retired
);

  // State encoding is visible on the debug port, so it is fixed here.
  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  // Latched operation class.
  localparam logic [2:0] OP_NONE = 3'd0;
  localparam logic [2:0] OP_R    = 3'd1;
  localparam logic [2:0] OP_SW   = 3'd2;
  localparam logic [2:0] OP_LW   = 3'd3;
  localparam logic [2:0] OP_BEQ  = 3'd4;
  localparam logic [2:0] OP_ILL  = 3'd5;

  // The last tolerated wait cycle. An unanswered cycle at this count halts.
  localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

  // Map the raw opcode onto an operation class.
  function automatic logic [2:0] classify(input logic [3:0] op);
    logic [2:0] cls;
    case (op)
      4'b0000: cls = OP_R;
      4'b0001: cls = OP_SW;
      4'b0010: cls = OP_LW;
      4'b0011: cls = OP_BEQ;
      default: cls = OP_ILL;
    endcase
    return cls;
  endfunction

  logic [2:0]       state_r;
  logic [2:0]       next_state_s;
  logic [2:0]       op_r;
  logic [2:0]       dec_op_s;
  logic [7:0]       wait_cnt_r;
  logic             wait_s;
  logic             retire_s;
  logic             timeout_hit_s;
  logic             timeout_r;
  logic             illegal_r;
  logic [CNT_W-1:0] retired_r;

  assign dec_op_s = classify(opcode);

  // A wait cycle is a request-issuing state (FETCH/MEM) with no ready.
  assign wait_s = ((state_r == S_FETCH) || (state_r == S_MEM)) && !mem_ready;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= S_FETCH;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic, plus retire and timeout events tied to transitions.
  always_comb begin
    next_state_s  = state_r;
    retire_s      = 1'b0;
    timeout_hit_s = 1'b0;
    case (state_r)
      S_FETCH: begin
        // Ready on the last tolerated cycle still completes normally.
        if (mem_ready) begin
          next_state_s = S_DECODE;
        end else if (wait_cnt_r == WAIT_LAST) begin
          next_state_s  = S_HALT;
          timeout_hit_s = 1'b1;
        end else begin
          next_state_s = S_FETCH;
        end
      end
      S_DECODE: begin
        if (dec_op_s == OP_ILL) begin
          next_state_s = S_FETCH;
        end else begin
          next_state_s = S_EXEC;
        end
      end
      S_EXEC: begin
        case (op_r)
          OP_R:    next_state_s = S_WB;
          OP_SW:   next_state_s = S_MEM;
          OP_LW:   next_state_s = S_MEM;
          OP_BEQ: begin
            next_state_s = S_FETCH;
            retire_s     = 1'b1;
          end
          default: next_state_s = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (mem_ready) begin
          if (op_r == OP_SW) begin
            next_state_s = S_FETCH;
            retire_s     = 1'b1;
          end else begin
            next_state_s = S_WB;
          end
        end else if (wait_cnt_r == WAIT_LAST) begin
          next_state_s  = S_HALT;
          timeout_hit_s = 1'b1;
        end else begin
          next_state_s = S_MEM;
        end
      end
      S_WB: begin
        next_state_s = S_FETCH;
        retire_s     = 1'b1;
      end
      S_HALT:  next_state_s = S_HALT;
      default: next_state_s = S_FETCH;
    endcase
  end

  // Operation class, captured once per instruction in DECODE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_r <= OP_NONE;
    end else if (state_r == S_DECODE) begin
      op_r <= dec_op_s;
    end else begin
      op_r <= op_r;
    end
  end

  // Wait counter: counts consecutive unanswered cycles within one state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt_r <= 8'd0;
    end else if (next_state_s != state_r) begin
      wait_cnt_r <= 8'd0;
    end else if (wait_s) begin
      wait_cnt_r <= wait_cnt_r + 8'd1;
    end else begin
      wait_cnt_r <= 8'd0;
    end
  end

  // Status flags: illegal pulses for one cycle, timeout holds until reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      illegal_r <= 1'b0;
      timeout_r <= 1'b0;
    end else begin
      illegal_r <= (state_r == S_DECODE) && (dec_op_s == OP_ILL);
      timeout_r <= timeout_r | timeout_hit_s;
    end
  end

  // Retired-instruction counter, wraps naturally at full scale.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      retired_r <= '0;
    end else if (retire_s) begin
      retired_r <= retired_r + CNT_W'(1);
    end else begin
      retired_r <= retired_r;
    end
  end

  // Control outputs. They are forced low while rst is high so an in-flight
  // request is dropped immediately rather than reissued from FETCH.
  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    iord       = 1'b0;
    ir_we      = 1'b0;
    pc_we      = 1'b0;
    pc_src     = 1'b0;
    reg_we     = 1'b0;
    mem_to_reg = 1'b0;
    if (rst) begin
      mem_req = 1'b0;
    end else begin
      case (state_r)
        S_FETCH: begin
          mem_req = 1'b1;
          iord    = 1'b0;
          if (mem_ready) begin
            ir_we = 1'b1;
            pc_we = 1'b1;
          end else begin
            ir_we = 1'b0;
            pc_we = 1'b0;
          end
        end
        S_EXEC: begin
          if (op_r == OP_BEQ) begin
            pc_src = 1'b1;
            pc_we  = zero;
          end else begin
            pc_src = 1'b0;
            pc_we  = 1'b0;
          end
        end
        S_MEM: begin
          mem_req = 1'b1;
          iord    = 1'b1;
          mem_we  = (op_r == OP_SW);
        end
        S_WB: begin
          reg_we     = 1'b1;
          mem_to_reg = (op_r == OP_LW);
        end
        default: mem_req = 1'b0;
      endcase
    end
  end

  assign state   = state_r;
  assign illegal = illegal_r;
  assign timeout = timeout_r;
  assign retired = retired_r;

endmodule

// File: tb/tb_multicycle_controller.sv
// ---------------------------------------------------------------------------
// tb_multicycle_controller
//
// A reference model expands each instruction (opcode, zero, memory delays)
// into the expected per-cycle trace of state, controls and status. The bench
// replays the memory responses from that trace and compares the DUT on every
// cycle.
// ---------------------------------------------------------------------------
module tb_multicycle_controller;

  logic        clk;
  logic        rst;
  logic [3:0]  opcode;
  logic        zero;
  logic        mem_ready;
  logic        mem_req;
  logic        mem_we;
  logic        iord;
  logic        ir_we;
  logic        pc_we;
  logic        pc_src;
  logic        reg_we;
  logic        mem_to_reg;
  logic [2:0]  state;
  logic        illegal;
  logic        timeout;
  logic [15:0] retired;

  multicycle_controller #(.MAX_WAIT(15), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_we(ir_we),
    .pc_we(pc_we), .pc_src(pc_src), .reg_we(reg_we), .mem_to_reg(mem_to_reg),
    .state(state), .illegal(illegal), .timeout(timeout), .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Control vector bit positions.
  localparam logic [7:0] C_REQ   = 8'h80;
  localparam logic [7:0] C_WE    = 8'h40;
  localparam logic [7:0] C_IORD  = 8'h20;
  localparam logic [7:0] C_IRWE  = 8'h10;
  localparam logic [7:0] C_PCWE  = 8'h08;
  localparam logic [7:0] C_PCSRC = 8'h04;
  localparam logic [7:0] C_REGWE = 8'h02;
  localparam logic [7:0] C_M2R   = 8'h01;

  typedef struct packed {
    logic        rdy;
    logic [3:0]  op;
    logic        z;
    logic [2:0]  st;
    logic [7:0]  ctl;
    logic        ill;
    logic        tmo;
    logic [15:0] ret;
  } ent_t;

  ent_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   m_ret   = 0;
  bit   m_pill  = 1'b0;
  bit   m_tmo   = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push(input logic rdy, input logic [3:0] op, input logic z,
                      input logic [2:0] st, input logic [7:0] ctl);
    ent_t e;
    e.rdy = rdy; e.op = op; e.z = z; e.st = st; e.ctl = ctl;
    e.ill = m_pill; e.tmo = m_tmo; e.ret = 16'(m_ret);
    m_pill = 1'b0;
    q.push_back(e);
  endtask

  function automatic logic [3:0] rop();
    return 4'($urandom_range(0, 15));
  endfunction

  function automatic logic rbit();
    return 1'($urandom_range(0, 1));
  endfunction

  // Expand one instruction into its expected cycles.
  task automatic add_instr(input logic [3:0] op, input logic z, input int df, input int dm);
    logic [7:0] mctl;
    for (int i = 0; i < df; i++) push(1'b0, rop(), rbit(), 3'd0, C_REQ);
    push(1'b1, rop(), rbit(), 3'd0, C_REQ | C_IRWE | C_PCWE);
    push(rbit(), op, rbit(), 3'd1, 8'h00);
    if (op > 4'd3) begin
      m_pill = 1'b1;
      return;
    end
    if (op == 4'd3) begin
      push(rbit(), rop(), z, 3'd2, C_PCSRC | (z ? C_PCWE : 8'h00));
      m_ret++;
      return;
    end
    push(rbit(), rop(), rbit(), 3'd2, 8'h00);
    if (op == 4'd0) begin
      push(rbit(), rop(), rbit(), 3'd4, C_REGWE);
      m_ret++;
      return;
    end
    mctl = C_REQ | C_IORD | ((op == 4'd1) ? C_WE : 8'h00);
    for (int i = 0; i < dm; i++) push(1'b0, rop(), rbit(), 3'd3, mctl);
    push(1'b1, rop(), rbit(), 3'd3, mctl);
    if (op == 4'd1) begin
      m_ret++;
      return;
    end
    push(rbit(), rop(), rbit(), 3'd4, C_REGWE | C_M2R);
    m_ret++;
  endtask

  // Replay the queued trace; called at a negedge, returns at a negedge.
  task automatic run_trace();
    ent_t e;
    while (q.size() > 0) begin
      e = q.pop_front();
      mem_ready = e.rdy;
      opcode    = e.op;
      zero      = e.z;
      #1;
      check("ctl", {21'd0, state, mem_req, mem_we, iord, ir_we, pc_we, pc_src,
                    reg_we, mem_to_reg}, {21'd0, e.st, e.ctl});
      check("illegal", {31'd0, illegal}, {31'd0, e.ill});
      check("timeout", {31'd0, timeout}, {31'd0, e.tmo});
      check("retired", {16'd0, retired}, {16'd0, e.ret});
      @(negedge clk);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ret  = 0;
    m_pill = 1'b0;
    m_tmo  = 1'b0;
  endtask

  initial begin
    logic [3:0] op;
    rst = 1'b1; mem_ready = 1'b0; opcode = 4'd0; zero = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_state", {29'd0, state}, 32'd0);
    check("rst_req", {31'd0, mem_req}, 32'd0);
    check("rst_retired", {16'd0, retired}, 32'd0);
    check("rst_flags", {30'd0, illegal, timeout}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed: R-type, LW with 3 waits, SW, BEQ taken/not, illegal, 14 fetch waits.
    add_instr(4'd0, 1'b0, 0, 0);
    add_instr(4'd2, 1'b0, 0, 3);
    add_instr(4'd1, 1'b0, 0, 0);
    add_instr(4'd3, 1'b1, 0, 0);
    add_instr(4'd3, 1'b0, 0, 0);
    add_instr(4'd7, 1'b0, 0, 0);
    add_instr(4'd0, 1'b0, 14, 0);
    add_instr(4'd2, 1'b0, 1, 14);
    run_trace();

    // Random instruction stream.
    for (int n = 0; n < 60; n++) begin
      case ($urandom_range(0, 5))
        0: op = 4'd0;
        1: op = 4'd1;
        2: op = 4'd2;
        3: op = 4'd3;
        default: op = 4'($urandom_range(4, 15));
      endcase
      add_instr(op, rbit(),
                ($urandom_range(0, 7) == 0) ? 14 : int'($urandom_range(0, 3)),
                ($urandom_range(0, 7) == 0) ? 14 : int'($urandom_range(0, 3)));
    end
    run_trace();

    // Fetch timeout: 15 unanswered cycles, then HALT with sticky timeout.
    for (int i = 0; i < 15; i++) push(1'b0, rop(), rbit(), 3'd0, C_REQ);
    m_tmo = 1'b1;
    for (int i = 0; i < 6; i++) push(rbit(), rop(), rbit(), 3'd5, 8'h00);
    run_trace();

    rst = 1'b1;
    #1;
    check("tmo_rst_state", {29'd0, state}, 32'd0);
    check("tmo_rst_flag", {31'd0, timeout}, 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // One retired R-type, then an SW stalled in MEM that is reset mid-access.
    add_instr(4'd0, 1'b0, 0, 0);
    push(1'b1, rop(), rbit(), 3'd0, C_REQ | C_IRWE | C_PCWE);
    push(1'b0, 4'd1, rbit(), 3'd1, 8'h00);
    push(1'b0, rop(), rbit(), 3'd2, 8'h00);
    push(1'b0, rop(), rbit(), 3'd3, C_REQ | C_IORD | C_WE);
    push(1'b0, rop(), rbit(), 3'd3, C_REQ | C_IORD | C_WE);
    run_trace();
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_state", {29'd0, state}, 32'd0);
    check("mid_rst_req", {29'd0, mem_req, mem_we, iord}, 32'd0);
    check("mid_rst_retired", {16'd0, retired}, 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    add_instr(4'd2, 1'b0, 1, 1);
    add_instr(4'd3, 1'b1, 0, 0);
    run_trace();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
